imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Write-side companion to the read-only instruction memory. It accepts a byte stream over a valid/ready handshake and packs the bytes little-endian into DATA_WIDTH words. Each completed word is written into instruction memory through a single-cycle write strobe at consecutive addresses starting at 0. It sits between the host/boot byte source and the memory write port, and holds o_busy high so the core can be kept in reset during a load.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8; BYTES = DATA_WIDTH/8.
ADDR_WIDTH, 8, word-address width; memory depth = 2**ADDR_WIDTH words.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  reset, asynchronous, active-high.
i_start  input  1  single-cycle request to begin a load; sampled only in IDLE.
i_word_count  input  ADDR_WIDTH+1  number of words to load, latched on an accepted i_start.
i_byte_valid  input  1  byte source has data.
i_byte  input  8  byte data.
o_byte_ready  output  1  loader accepts a byte this cycle.
o_we  output  1  memory write strobe, one cycle per word.
o_waddr  output  ADDR_WIDTH  word write address.
o_wdata  output  DATA_WIDTH  packed word.
o_busy  output  1  high while a load is in progress.
o_done  output  1  one-cycle pulse when a load completes.
o_err  output  1  one-cycle pulse when i_start is rejected.

Behaviour:
- Reset (async, i_rst=1): state IDLE; all outputs 0; address, byte index, word counter and shift register cleared. A partial word in flight is discarded and no write is issued. Reset mid-load leaves memory with only the already-written words.
- States: IDLE, RECV, WRITE, DONE.
- IDLE: o_byte_ready=0, o_busy=0.
  - i_start with count==0: go to DONE (o_done pulses next cycle, no writes).
  - i_start with count > 2**ADDR_WIDTH: o_err=1 next cycle; stay IDLE.
  - Otherwise: latch count, addr=0, idx=0, go to RECV.
- RECV: o_byte_ready=1, o_busy=1.
  - A byte transfers when i_byte_valid & o_byte_ready. It is placed at lane idx (bits 8*idx+7:8*idx); the first byte is the LSB.
  - idx increments per accepted byte. On acceptance with idx==BYTES-1, go to WRITE and reset idx to 0.
  - i_byte_valid low: hold state; no timeout.
- WRITE (exactly one cycle): o_we=1, o_waddr=addr, o_wdata=packed word, o_byte_ready=0.
  - Next state: DONE if words written == count; else RECV with addr+1.
  - Latency: last byte accepted on edge N gives o_we high for the cycle after edge N.
- DONE (one cycle): o_done=1, o_busy=0, then IDLE.
- i_start is ignored outside IDLE (no err, no restart).
- o_wdata and o_waddr hold their last values when o_we=0. Consumers must qualify them with o_we.
- A full load (count = 2**ADDR_WIDTH) ends at addr = 2**ADDR_WIDTH-1. The address never wraps within a load.
- Throughput: with continuous valid, one word per BYTES+1 cycles.

Decomposition:
- Shared package: state enum (IDLE/RECV/WRITE/DONE), BYTES_PER_WORD = DATA_WIDTH/8, and the lane-index width $clog2(BYTES_PER_WORD).
- One sub-module: word_packer. Inputs: byte, lane index, load strobe, clear. Output: DATA_WIDTH register.
- The FSM, address counter and word counter stay in imem_loader.

Test Plan:
- Single-word load: start, count=1, bytes 0x78,0x56,0x34,0x12 back-to-back -> o_we one cycle after the 4th byte with waddr=0, wdata=0x12345678; o_done the following cycle; o_busy high from cycle after start until DONE.
- Stalled source: count=2, 8 bytes with i_byte_valid toggling every other cycle -> two writes, addr 0 then 1, correct words; no byte lost or duplicated; o_byte_ready=0 during each WRITE cycle.
- Boundary counts: count=0 -> o_done only, no o_we. Count=257 with ADDR_WIDTH=8 -> o_err pulse, stays IDLE. Count=256 -> last write at waddr=0xFF, then o_done.
- Start while busy: assert i_start mid-load with a new count -> ignored; original count completes; no o_err.
- Async reset mid-word: assert i_rst after 2 of 4 bytes, between clock edges -> outputs 0 immediately, no o_we. A subsequent load of count=1 writes waddr=0 with only the new bytes.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing helpers for the instruction-memory byte loader.
// Word geometry is derived from the DATA_WIDTH each instance is built with.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEFAULT_DATA_WIDTH = 32;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    // Lane index is kept at least one bit wide so 8-bit words still elaborate.
    function automatic int lane_width(input int data_width);
        return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(DEFAULT_DATA_WIDTH);
    localparam int LANE_W         = lane_width(DEFAULT_DATA_WIDTH);

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles a little-endian word by dropping each byte into its lane.
// Clear has priority over load; lanes not yet written keep their old bytes.
module word_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int LANE_W     = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_byte,
    input  logic [LANE_W-1:0]     i_lane,
    input  logic                  i_load,
    input  logic                  i_clear,
    output logic [DATA_WIDTH-1:0] o_word
);

    logic [DATA_WIDTH-1:0] word_q, word_d;

    always_comb begin
        word_d = word_q;
        if (i_clear) begin
            word_d = '0;
        end else if (i_load) begin
            word_d[8*i_lane +: 8] = i_byte;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign o_word = word_q;

endmodule

// File: rtl/imem_loader.sv
// Packs a byte stream into words and writes them to instruction memory from address 0.
// One write cycle per word; o_busy covers RECV and WRITE so the core can be held off.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_word_count,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte,
    output logic                  o_byte_ready,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int BYTES = bytes_per_word(DATA_WIDTH);
    localparam int LW    = lane_width(DATA_WIDTH);
    localparam logic [LW-1:0]       LAST_LANE = LW'(BYTES - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
    logic [LW-1:0]         idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  pk_load, pk_clear;
    logic [DATA_WIDTH-1:0] packed_word;

    word_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_W     (LW)
    ) u_packer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_byte  (i_byte),
        .i_lane  (idx_q),
        .i_load  (pk_load),
        .i_clear (pk_clear),
        .o_word  (packed_word)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        count_d  = count_q;
        wcnt_d   = wcnt_q;
        idx_d    = idx_q;
        err_d    = 1'b0;
        pk_load  = 1'b0;
        pk_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_word_count == '0) begin
                        state_d = ST_DONE;
                    end else if (i_word_count > DEPTH) begin
                        err_d = 1'b1;
                    end else begin
                        count_d  = i_word_count;
                        addr_d   = '0;
                        wcnt_d   = '0;
                        idx_d    = '0;
                        pk_clear = 1'b1;
                        state_d  = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (i_byte_valid) begin
                    pk_load = 1'b1;
                    if (idx_q == LAST_LANE) begin
                        idx_d   = '0;
                        state_d = ST_WRITE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                // Capture what is on the bus so it stays stable between writes.
                waddr_d = addr_q;
                wdata_d = packed_word;
                wcnt_d  = wcnt_q + 1'b1;
                if (wcnt_q + 1'b1 == count_q) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_RECV;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            count_q <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign o_byte_ready = (state_q == ST_RECV);
    assign o_we         = (state_q == ST_WRITE);
    assign o_busy       = (state_q == ST_RECV) || (state_q == ST_WRITE);
    assign o_done       = (state_q == ST_DONE);
    assign o_err        = err_q;
    assign o_waddr      = o_we ? addr_q : waddr_q;
    assign o_wdata      = o_we ? packed_word : wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected writes come from a byte-list model.
module tb_imem_loader;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int BYTES = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [AW:0]   i_word_count;
    logic          i_byte_valid;
    logic [7:0]    i_byte;
    logic          o_byte_ready;
    logic          o_we;
    logic [AW-1:0] o_waddr;
    logic [DW-1:0] o_wdata;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    always #5 clk = ~clk;

    imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (i_start),
        .i_word_count (i_word_count),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .o_we         (o_we),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] bytes_q[$];
    int         n_we   = 0;
    int         n_done = 0;
    int         n_err  = 0;

    // Every write strobe is matched against the model's next expected word.
    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (o_we) begin
                n_we++;
                check_eq("we_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("waddr", o_waddr, e.a);
                    check_eq("wdata", o_wdata, e.d);
                end
                check_eq("ready_in_write", o_byte_ready, 0);
            end
            if (o_done) n_done++;
            if (o_err)  n_err++;
        end
    end

    // Reference: word w is bytes 4w..4w+3, first byte least significant.
    task automatic build_model(input int count);
        logic [DW-1:0] d;
        bytes_q.delete();
        for (int i = 0; i < count * BYTES; i++) bytes_q.push_back(8'($urandom));
        for (int w = 0; w < count; w++) begin
            d = '0;
            for (int k = 0; k < BYTES; k++) d = d + (DW'(bytes_q[w*BYTES+k]) << (8*k));
            exp_q.push_back('{a: AW'(w), d: d});
        end
    endtask

    task automatic start_load(input int count);
        @(negedge clk);
        i_start      = 1'b1;
        i_word_count = (AW+1)'(count);
        @(negedge clk);
        i_start = 1'b0;
        check_eq("busy_after_start", o_busy, 1);
    endtask

    // vld_pct < 0 means valid alternates every cycle.
    task automatic send_bytes(input int vld_pct, input int restart_at);
        int  i     = 0;
        int  guard = 0;
        bit  acc;
        bit  fired = 0;
        while (i < bytes_q.size() && guard < 20000) begin
            @(negedge clk);
            i_start      = 1'b0;
            i_byte_valid = (vld_pct < 0) ? guard[0] : ($urandom_range(99) < vld_pct);
            i_byte       = bytes_q[i];
            if (i == restart_at && !fired) begin
                i_start      = 1'b1;
                i_word_count = (AW+1)'(3);
                fired        = 1;
            end
            acc = i_byte_valid && o_byte_ready;
            @(posedge clk);
            if (acc) i++;
            guard++;
        end
        if (guard >= 20000) check_eq("byte_timeout", i, bytes_q.size());
        @(negedge clk);
        i_byte_valid = 1'b0;
        i_start      = 1'b0;
    endtask

    task automatic wait_done(input int base_done);
        int g = 0;
        while (n_done == base_done && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        check_eq("done_seen", n_done - base_done, 1);
    endtask

    task automatic run_load(input int count, input int vld_pct, input int restart_at);
        int we0   = n_we;
        int done0 = n_done;
        int err0  = n_err;
        build_model(count);
        start_load(count);
        send_bytes(vld_pct, restart_at);
        wait_done(done0);
        check_eq("write_count", n_we - we0, count);
        check_eq("model_drained", exp_q.size(), 0);
        check_eq("no_err", n_err - err0, 0);
        repeat (3) @(negedge clk);
        check_eq("idle_after_load", o_busy, 0);
        exp_q.delete();
    endtask

    initial begin
        int we0;
        rst          = 1'b1;
        i_start      = 1'b0;
        i_word_count = '0;
        i_byte_valid = 1'b0;
        i_byte       = '0;
        #12;
        check_eq("rst_we", o_we, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_ready", o_byte_ready, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_err", o_err, 0);
        check_eq("rst_waddr", o_waddr, 0);
        check_eq("rst_wdata", o_wdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single word, back-to-back bytes, exact timing.
        exp_q.push_back('{a: '0, d: 32'h1234_5678});
        bytes_q = '{8'h78, 8'h56, 8'h34, 8'h12};
        start_load(1);
        for (int k = 0; k < BYTES; k++) begin
            i_byte_valid = 1'b1;
            i_byte       = bytes_q[k];
            check_eq("ready_recv", o_byte_ready, 1);
            @(negedge clk);
        end
        i_byte_valid = 1'b0;
        check_eq("we_after_last_byte", o_we, 1);
        check_eq("busy_in_write", o_busy, 1);
        @(negedge clk);
        check_eq("done_pulse", o_done, 1);
        check_eq("busy_in_done", o_busy, 0);
        check_eq("we_after_write", o_we, 0);
        check_eq("waddr_hold", o_waddr, 0);
        check_eq("wdata_hold", o_wdata, 32'h1234_5678);
        @(negedge clk);
        check_eq("done_one_cycle", o_done, 0);

        // Zero count: done only.
        we0 = n_we;
        @(negedge clk);
        i_start      = 1'b1;
        i_word_count = '0;
        @(negedge clk);
        i_start = 1'b0;
        check_eq("cnt0_done", o_done, 1);
        check_eq("cnt0_busy", o_busy, 0);
        @(negedge clk);
        check_eq("cnt0_done_end", o_done, 0);
        check_eq("cnt0_no_we", n_we - we0, 0);

        // Oversize count rejected.
        @(negedge clk);
        i_start      = 1'b1;
        i_word_count = (AW+1)'(257);
        @(negedge clk);
        i_start = 1'b0;
        check_eq("cnt257_err", o_err, 1);
        check_eq("cnt257_busy", o_busy, 0);
        check_eq("cnt257_ready", o_byte_ready, 0);
        @(negedge clk);
        check_eq("cnt257_err_end", o_err, 0);
        check_eq("cnt257_idle", o_busy, 0);

        // Stalled source, random loads, start while busy, full-depth load.
        run_load(2, -1, -1);
        for (int t = 0; t < 6; t++) run_load($urandom_range(1, 6), $urandom_range(30, 100), -1);
        run_load(4, 80, 5);
        run_load(256, 100, -1);

        // Async reset between edges after two bytes of a word.
        we0 = n_we;
        build_model(1);
        start_load(1);
        for (int k = 0; k < 2; k++) begin
            i_byte_valid = 1'b1;
            i_byte       = bytes_q[k];
            @(negedge clk);
        end
        i_byte_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_busy", o_busy, 0);
        check_eq("arst_ready", o_byte_ready, 0);
        check_eq("arst_we", o_we, 0);
        check_eq("arst_waddr", o_waddr, 0);
        check_eq("arst_wdata", o_wdata, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("arst_no_we", n_we - we0, 0);
        run_load(1, 100, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
